// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_ctrl
// Brief    : Round-robin shared-memory controller. Serialises NUM_PORTS
//            requestors onto one word-organised array; every access
//            completes LATENCY cycles after it is sampled, with a one-cycle
//            per-port done pulse, read data and an error flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_ctrl #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          i_req,
    input  logic [NUM_PORTS-1:0]          i_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   i_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   i_wdata,
    output logic [NUM_PORTS-1:0]          o_done,
    output logic [NUM_PORTS*DATA_W-1:0]   o_rdata,
    output logic [NUM_PORTS-1:0]          o_err,
    output logic                          o_busy
);

    localparam int c_pw = (NUM_PORTS > 1)   ? $clog2(NUM_PORTS)   : 1;
    localparam int c_cw = (LATENCY > 1)     ? $clog2(LATENCY)     : 1;
    localparam int c_iw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_ww = ADDR_W - 2;
    localparam logic [c_cw-1:0] c_cnt_load = c_cw'(LATENCY - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [c_pw-1:0]     r_ptr;
    logic [c_cw-1:0]     r_cnt;
    logic [c_pw-1:0]     r_lat_port;
    logic                r_lat_wr;
    logic [ADDR_W-1:0]   r_lat_addr;
    logic [DATA_W-1:0]   r_lat_wdata;

    logic [NUM_PORTS-1:0]        r_done;
    logic [NUM_PORTS-1:0]        r_err;
    logic [NUM_PORTS*DATA_W-1:0] r_rdata;

    logic [DATA_W-1:0]   r_mem [0:DEPTH_WORDS-1];

    logic                w_found;
    logic                w_hi_found;
    logic [c_pw-1:0]     w_hi;
    logic [c_pw-1:0]     w_lo;
    logic [c_pw-1:0]     w_grant;
    logic [c_pw-1:0]     w_ptr_next;

    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    logic                w_load;
    logic                w_fire;

    logic [c_pw-1:0]     w_op_port;
    logic                w_op_wr;
    logic [ADDR_W-1:0]   w_op_addr;
    logic [DATA_W-1:0]   w_op_wdata;
    logic [c_ww-1:0]     w_op_word;
    logic [c_iw-1:0]     w_op_idx;
    logic                w_op_err;

    // Round-robin pick: lowest requester at/after the pointer, else lowest overall
    always_comb begin
        w_found    = 1'b0;
        w_hi_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (i_req[p]) begin
                w_found = 1'b1;
                w_lo    = c_pw'(p);
                if (c_pw'(p) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi       = c_pw'(p);
                end
            end
        end
        w_grant    = w_hi_found ? w_hi : w_lo;
        w_ptr_next = (w_grant == c_pw'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;
    end

    // Steer the granted port's command fields
    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (c_pw'(p) == w_grant) begin
                w_sel_wr    = i_wr[p];
                w_sel_addr  = i_addr[p*ADDR_W +: ADDR_W];
                w_sel_wdata = i_wdata[p*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic; w_fire marks the edge at which the access completes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_BUSY;
                    w_load       = 1'b1;
                    w_fire       = (LATENCY == 1);
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else if ((LATENCY > 1) && (r_cnt == c_cw'(1))) begin
                    w_fire = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Completing access: with single-cycle latency it completes at the grant edge,
    // so the live port inputs are used instead of the latched copy
    always_comb begin
        w_op_port  = (r_state == S_IDLE) ? w_grant     : r_lat_port;
        w_op_wr    = (r_state == S_IDLE) ? w_sel_wr    : r_lat_wr;
        w_op_addr  = (r_state == S_IDLE) ? w_sel_addr  : r_lat_addr;
        w_op_wdata = (r_state == S_IDLE) ? w_sel_wdata : r_lat_wdata;
        w_op_word  = w_op_addr[ADDR_W-1:2];
        w_op_idx   = w_op_word[c_iw-1:0];
        w_op_err   = (w_op_addr[1:0] != 2'b00) ||
                     (64'(w_op_word) >= 64'(DEPTH_WORDS));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant latch, latency counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_lat_port  <= '0;
            r_lat_wr    <= 1'b0;
            r_lat_addr  <= '0;
            r_lat_wdata <= '0;
        end else if (w_load) begin
            r_ptr       <= w_ptr_next;
            r_cnt       <= c_cnt_load;
            r_lat_port  <= w_grant;
            r_lat_wr    <= w_sel_wr;
            r_lat_addr  <= w_sel_addr;
            r_lat_wdata <= w_sel_wdata;
        end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Done/error pulses and per-port held read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= '0;
            r_err   <= '0;
            r_rdata <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (w_fire) begin
                r_done[w_op_port] <= 1'b1;
                r_err[w_op_port]  <= w_op_err;
                if (!w_op_err && !w_op_wr) begin
                    r_rdata[w_op_port*DATA_W +: DATA_W] <= r_mem[w_op_idx];
                end
            end
        end
    end

    // Backing array: contents survive reset; a write commits at the done edge
    always_ff @(posedge clk) begin
        if (!rst && w_fire && w_op_wr && !w_op_err) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;
    assign o_busy  = (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_ctrl
// Brief    : Self-checking bench for mem_arbiter_ctrl: transaction-level
//            reference model compared every cycle, directed scenarios with
//            literal expectations, randomized traffic, and a LATENCY=1 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_ctrl;

    localparam int N   = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int DEP = 64;
    localparam int L   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, wr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    o_done, o_err;
    logic [N*DW-1:0] o_rdata;
    logic            o_busy;

    logic [N-1:0]    b_req, b_wr;
    logic [N*AW-1:0] b_addr;
    logic [N*DW-1:0] b_wdata;
    logic [N-1:0]    b_done, b_err;
    logic [N*DW-1:0] b_rdata;
    logic            b_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    mem_arbiter_ctrl #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW),
                       .DEPTH_WORDS(DEP), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_wr(wr), .i_addr(addr),
        .i_wdata(wdata), .o_done(o_done), .o_rdata(o_rdata),
        .o_err(o_err), .o_busy(o_busy));

    mem_arbiter_ctrl #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW),
                       .DEPTH_WORDS(DEP), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .i_req(b_req), .i_wr(b_wr), .i_addr(b_addr),
        .i_wdata(b_wdata), .o_done(b_done), .o_rdata(b_rdata),
        .o_err(b_err), .o_busy(b_busy));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] m_mem [int];
    bit            m_act = 0;
    int            m_T, m_done_c, m_port, m_ptr = 0;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [N-1:0]  e_done = '0, e_err = '0;
    logic [DW-1:0] e_rdata [N];
    bit            e_busy = 0;

    task automatic model_step();
        bit found;
        int q, w;
        cyc++;
        e_done = '0;
        e_err  = '0;
        if (rst) begin
            m_act  = 0;
            m_ptr  = 0;
            e_busy = 0;
            for (int p = 0; p < N; p++) e_rdata[p] = '0;
            return;
        end
        // previous cycle was free: the arbiter sampled the requests then
        if (!m_act || (cyc - 1) > m_done_c) begin
            m_act = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                q = (m_ptr + k) % N;
                if (!found && req[q]) begin
                    found    = 1;
                    m_act    = 1;
                    m_port   = q;
                    m_T      = cyc - 1;
                    m_done_c = m_T + L;
                    m_wr     = wr[q];
                    m_addr   = addr[q*AW +: AW];
                    m_wd     = wdata[q*DW +: DW];
                    m_ptr    = (q + 1) % N;
                end
            end
        end
        if (m_act && cyc == m_done_c) begin
            w = int'(m_addr) / 4;
            e_done[m_port] = 1'b1;
            if ((m_addr % 4) != 0 || w >= DEP) e_err[m_port] = 1'b1;
            else if (m_wr) m_mem[w] = m_wd;
            else e_rdata[m_port] = m_mem.exists(w) ? m_mem[w] : '0;
        end
        e_busy = m_act && cyc > m_T && cyc <= m_done_c;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            for (int p = 0; p < N; p++) begin
                chk($sformatf("done[%0d]", p), o_done[p], e_done[p]);
                if (e_done[p]) chk($sformatf("err[%0d]", p), o_err[p], e_err[p]);
                chk($sformatf("rdata[%0d]", p), o_rdata[p*DW +: DW], e_rdata[p]);
            end
            chk("busy", o_busy, e_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p]             = 1'b1;
        wr[p]              = w;
        addr[p*AW +: AW]   = a;
        wdata[p*DW +: DW]  = d;
    endtask

    task automatic wait_done(input int p, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_done[p]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout waiting done[%0d] (cycle %0d)", p, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic bit in_flight(input int p);
        return m_act && m_port == p && cyc > m_T && cyc < m_done_c;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 7)      return AW'($urandom_range(0, 7) * 4);
        else if (k < 9) return AW'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
        else            return AW'($urandom_range(DEP, 16383) * 4);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int c, a, b, a0, a1, a2;
        int dc [$];
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
        b_req = '0; b_wr = '0; b_addr = '0; b_wdata = '0;
        step(); step(); step();
        chk("reset_done", o_done, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_rdata", o_rdata, 0);
        rst = 1'b0;

        // 1: write then read back through the other port
        step(); c = cyc;
        set_port(0, 1, 16'h0010, 32'hDEADBEEF);
        wait_done(0, a);
        chk("t1_wr_lat", a - c, 4);
        chk("t1_wr_err", o_err[0], 0);
        req[0] = 1'b0;
        set_port(1, 0, 16'h0010, 32'h0);
        wait_done(1, b);
        chk("t1_rd_lat", b - a, 5);
        chk("t1_rdata", o_rdata[DW +: DW], 32'hDEADBEEF);
        chk("t1_rd_err", o_err[1], 0);
        req[1] = 1'b0;

        // 2: simultaneous requests after reset, then P0 re-requests
        do_reset(); c = cyc;
        set_port(0, 0, 16'h0010, 32'h0);
        set_port(1, 0, 16'h0014, 32'h0);
        wait_done(0, a0);
        chk("t2_p0_lat", a0 - c, 4);
        set_port(0, 0, 16'h0018, 32'h0);
        wait_done(1, a1);
        chk("t2_p1_lat", a1 - c, 9);
        req[1] = 1'b0;
        wait_done(0, a2);
        chk("t2_p0_again", a2 - c, 14);
        req[0] = 1'b0;

        // 3: misaligned write errors and leaves memory untouched
        step(); c = cyc;
        set_port(1, 1, 16'h0013, 32'h12345678);
        wait_done(1, a);
        chk("t3_lat", a - c, 4);
        chk("t3_err", o_err[1], 1);
        req[1] = 1'b0;
        set_port(0, 0, 16'h0010, 32'h0);
        wait_done(0, b);
        chk("t3_rdata", o_rdata[0 +: DW], 32'hDEADBEEF);
        chk("t3_rd_err", o_err[0], 0);
        req[0] = 1'b0;

        // 4: reset aborts an in-flight write
        step(); c = cyc;
        set_port(0, 1, 16'h0020, 32'hCAFEF00D);
        step(); step();
        rst = 1'b1; req[0] = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t4_no_done", o_done, 0);
            chk("t4_busy", o_busy, 0);
            step();
        end
        set_port(0, 0, 16'h0020, 32'h0);
        wait_done(0, a);
        chk("t4_rdata", o_rdata[0 +: DW], 32'h0);
        req[0] = 1'b0;

        // 5: request dropped while busy still completes, no regrant
        step(); c = cyc;
        set_port(0, 0, 16'h0040, 32'h0);
        step();
        req[0] = 1'b0;
        wait_done(0, a);
        chk("t5_lat", a - c, 4);
        step();
        chk("t5_idle1", o_busy, 0);
        step();
        chk("t5_idle2", o_busy, 0);

        // 6: LATENCY=1 build, back-to-back reads of consecutive words
        step(); c = cyc;
        b_req[0] = 1'b1; b_wr[0] = 1'b0; b_addr[0 +: AW] = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (b_done[0]) begin
                dc.push_back(cyc);
                b_addr[0 +: AW] = b_addr[0 +: AW] + AW'(4);
                chk("t6_err", b_err[0], 0);
            end
        end
        b_req[0] = 1'b0;
        chk("t6_count", dc.size(), 6);
        if (dc.size() >= 2) begin
            chk("t6_first", dc[0] - c, 1);
            for (int k = 1; k < dc.size(); k++) chk("t6_gap", dc[k] - dc[k-1], 2);
        end

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
            for (int p = 0; p < N; p++) begin
                if (!req[p] || o_done[p]) begin
                    if (req[p] && $urandom_range(0, 1) == 0) req[p] = 1'b0;
                    else if (req[p] || $urandom_range(0, 3) == 0)
                        set_port(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end else if (in_flight(p) && $urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        req = '0;
        step(); step(); step(); step(); step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
